// File: rtl/axi_lite_mbox_array.sv
// rtl/axi_lite_mbox_array.sv - AXI4-Lite slave serving an array of mailbox word FIFOs with threshold/error interrupts
package ariane_axi_soc;
  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } aw_chan_lite_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_chan_lite_t;
  typedef struct packed { logic [1:0] resp; } b_chan_lite_t;
  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } ar_chan_lite_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_chan_lite_t;
  typedef struct packed {
    aw_chan_lite_t aw; logic aw_valid;
    w_chan_lite_t  w;  logic w_valid;
    logic          b_ready;
    ar_chan_lite_t ar; logic ar_valid;
    logic          r_ready;
  } req_lite_t;
  typedef struct packed {
    logic         aw_ready;
    logic         w_ready;
    b_chan_lite_t b; logic b_valid;
    logic         ar_ready;
    r_chan_lite_t r; logic r_valid;
  } resp_lite_t;
endpackage

module axi_lite_mbox_array #(
  parameter int unsigned               NumChannels  = 4,
  parameter int unsigned               FifoDepth    = 8,
  parameter int unsigned               AxiAddrWidth = 32,
  parameter int unsigned               AxiDataWidth = 32,
  parameter logic [AxiAddrWidth-1:0]   BaseAddr     = 32'h1040_2000,
  parameter type                       req_lite_t   = ariane_axi_soc::req_lite_t,
  parameter type                       resp_lite_t  = ariane_axi_soc::resp_lite_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  req_lite_t              slv_req_i,
  output resp_lite_t             slv_resp_o,
  output logic [NumChannels-1:0] irq_o,
  output logic [NumChannels-1:0] irq_edge_o
);
  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned ChW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam logic [AxiAddrWidth-1:0] Span = AxiAddrWidth'(NumChannels * 64);
  localparam logic [5:0] RegData = 6'h00, RegStatus = 6'h04, RegThresh = 6'h08,
                         RegIrqEn = 6'h0C, RegIrqStat = 6'h10, RegCtrl = 6'h14;

  typedef enum logic [1:0] {IDLE, WRESP, RRESP} state_e;
  state_e state_q, state_d;
  logic   last_was_wr_q;

  logic [AxiDataWidth-1:0] mem_q [NumChannels][FifoDepth];
  logic [PtrW-1:0] rd_ptr_q [NumChannels];
  logic [PtrW-1:0] wr_ptr_q [NumChannels];
  logic [CntW-1:0] count_q  [NumChannels];
  logic [CntW-1:0] cnt_nxt  [NumChannels];
  logic [7:0]      thresh_q [NumChannels];
  logic [2:0]      irq_en_q [NumChannels];
  logic [2:0]      irq_stat_q [NumChannels];
  logic [NumChannels-1:0] irq_q, irq_d, full, empty, thr_hit;
  logic [NumChannels-1:0] push, pop, flush, ovf, udf, th_we, en_we, w1c;

  logic [1:0]              bresp_q, rresp_q;
  logic [AxiDataWidth-1:0] rdata_q, r_data, wdata;
  logic                    b_err, r_err, wr_req, rd_req, wr_go, rd_go;

  logic [AxiAddrWidth-1:0] waddr, raddr, w_off, r_off;
  logic                    w_in, r_in;
  logic [ChW-1:0]          w_ch, r_ch;
  logic [5:0]              w_reg, r_reg;
  logic                    unused_bits;

  assign unused_bits = ^{slv_req_i.aw.prot, slv_req_i.ar.prot, slv_req_i.w.strb[3:1]};
  assign wdata  = slv_req_i.w.data;
  assign waddr  = slv_req_i.aw.addr;
  assign raddr  = slv_req_i.ar.addr;
  assign w_off  = waddr - BaseAddr;
  assign r_off  = raddr - BaseAddr;
  assign w_in   = (waddr >= BaseAddr) && (w_off < Span);
  assign r_in   = (raddr >= BaseAddr) && (r_off < Span);
  assign w_ch   = w_off[6 +: ChW];
  assign r_ch   = r_off[6 +: ChW];
  assign w_reg  = w_off[5:0];
  assign r_reg  = r_off[5:0];
  assign wr_req = slv_req_i.aw_valid & slv_req_i.w_valid;
  assign rd_req = slv_req_i.ar_valid;

  // Contested grants alternate; last_was_wr_q resets to 1 so the first contest goes to the read.
  always_comb begin
    state_d = state_q;
    wr_go   = 1'b0;
    rd_go   = 1'b0;
    if (state_q == IDLE && rst_ni) begin
      wr_go = wr_req && (!rd_req || !last_was_wr_q);
      rd_go = rd_req && (!wr_req || last_was_wr_q);
    end
    case (state_q)
      IDLE:    if (wr_go) state_d = WRESP; else if (rd_go) state_d = RRESP;
      WRESP:   if (slv_req_i.b_ready) state_d = IDLE;
      RRESP:   if (slv_req_i.r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slv_resp_o        = '0;
    slv_resp_o.aw_ready = wr_go;
    slv_resp_o.w_ready  = wr_go;
    slv_resp_o.ar_ready = rd_go;
    slv_resp_o.b_valid  = (state_q == WRESP);
    slv_resp_o.b.resp   = bresp_q;
    slv_resp_o.r_valid  = (state_q == RRESP);
    slv_resp_o.r.data   = rdata_q;
    slv_resp_o.r.resp   = rresp_q;
  end

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      full[c]    = (count_q[c] == CntW'(FifoDepth));
      empty[c]   = (count_q[c] == '0);
      cnt_nxt[c] = flush[c] ? '0 : count_q[c] + CntW'(push[c]) - CntW'(pop[c]);
      thr_hit[c] = (32'(cnt_nxt[c]) > 32'(thresh_q[c]));
    end
  end

  // Decode of the granted access into per-channel commit strobes and the response.
  always_comb begin
    push = '0; pop = '0; flush = '0; ovf = '0; udf = '0;
    th_we = '0; en_we = '0; w1c = '0;
    b_err = 1'b0; r_err = 1'b0; r_data = '0;
    if (wr_go) begin
      if (!w_in) b_err = 1'b1;
      else begin
        case (w_reg)
          RegData:    if (full[w_ch]) begin b_err = 1'b1; ovf[w_ch] = 1'b1; end
                      else push[w_ch] = 1'b1;
          RegThresh:  th_we[w_ch] = slv_req_i.w.strb[0];
          RegIrqEn:   en_we[w_ch] = slv_req_i.w.strb[0];
          RegIrqStat: w1c[w_ch]   = 1'b1;
          RegCtrl:    flush[w_ch] = wdata[0];
          default:    b_err = 1'b1;
        endcase
      end
    end
    if (rd_go) begin
      if (!r_in) r_err = 1'b1;
      else begin
        case (r_reg)
          RegData:    if (empty[r_ch]) begin r_err = 1'b1; udf[r_ch] = 1'b1; end
                      else begin r_data = mem_q[r_ch][rd_ptr_q[r_ch]]; pop[r_ch] = 1'b1; end
          RegStatus:  begin
                        r_data[0]         = empty[r_ch];
                        r_data[1]         = full[r_ch];
                        r_data[8 +: CntW] = count_q[r_ch];
                      end
          RegThresh:  r_data[7:0] = thresh_q[r_ch];
          RegIrqEn:   r_data[2:0] = irq_en_q[r_ch];
          RegIrqStat: r_data[2:0] = irq_stat_q[r_ch];
          default:    r_err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NumChannels; c++)
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      last_was_wr_q <= 1'b1;
      bresp_q       <= 2'b00;
      rresp_q       <= 2'b00;
      rdata_q       <= '0;
      rd_ptr_q      <= '{default: '0};
      wr_ptr_q      <= '{default: '0};
      count_q       <= '{default: '0};
      thresh_q      <= '{default: '0};
      irq_en_q      <= '{default: '0};
      irq_stat_q    <= '{default: '0};
      irq_q         <= '0;
      irq_d         <= '0;
    end else begin
      state_q <= state_d;
      if (wr_go) begin
        last_was_wr_q <= 1'b1;
        bresp_q       <= b_err ? 2'b10 : 2'b00;
      end
      if (rd_go) begin
        last_was_wr_q <= 1'b0;
        rresp_q       <= r_err ? 2'b10 : 2'b00;
        rdata_q       <= r_data;
      end
      for (int c = 0; c < NumChannels; c++) begin
        if (flush[c]) begin
          rd_ptr_q[c] <= '0;
          wr_ptr_q[c] <= '0;
        end else begin
          if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PtrW'(1);
          if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + PtrW'(1);
        end
        count_q[c] <= cnt_nxt[c];
        if (th_we[c]) thresh_q[c] <= wdata[7:0];
        if (en_we[c]) irq_en_q[c] <= wdata[2:0];
        // OR-ing the sets after the W1C mask lets a same-cycle set win over the clear.
        irq_stat_q[c] <= (irq_stat_q[c] & ~(w1c[c] ? wdata[2:0] : 3'b000))
                         | {udf[c], ovf[c], thr_hit[c]};
        irq_q[c] <= |(irq_stat_q[c] & irq_en_q[c]);
      end
      irq_d <= irq_q;
    end
  end

  assign irq_o      = irq_q;
  assign irq_edge_o = irq_q & ~irq_d;
endmodule

// File: tb/tb_axi_lite_mbox_array.sv
// tb/tb_axi_lite_mbox_array.sv - scoreboard bench for the AXI4-Lite mailbox array
module tb_axi_lite_mbox_array;
  localparam logic [31:0] BASE = 32'h1040_2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ariane_axi_soc::req_lite_t  req;
  ariane_axi_soc::resp_lite_t rsp;
  logic [3:0] irq, irq_edge;
  logic [3:0] snap_irq;
  int n_tests = 0;
  int n_fail = 0;
  int edge_cnt [4] = '{default: 0};
  logic [31:0] exp_q [$];
  logic [1:0]  exp_resp_q [$];
  logic        exp_gnt_q [$];

  axi_lite_mbox_array dut (
    .clk_i(clk), .rst_ni(rst_n), .slv_req_i(req), .slv_resp_o(rsp),
    .irq_o(irq), .irq_edge_o(irq_edge)
  );

  always #5 clk = ~clk;
  always @(negedge clk) for (int i = 0; i < 4; i++) if (irq_edge[i]) edge_cnt[i]++;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ra(input int ch, input int off);
    return BASE + 32'(ch * 64) + 32'(off);
  endfunction

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    req.aw.addr = a; req.w.data = d; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.b_ready = 1'b1;
    @(negedge clk);
    while (!rsp.aw_ready && n < 50) begin @(negedge clk); n++; end
    if (!rsp.aw_ready) begin
      n_tests++; n_fail++;
      $display("FAIL wr_accept_timeout addr=%h", a);
      req.aw_valid = 1'b0; req.w_valid = 1'b0; req.b_ready = 1'b0; resp = 2'bxx;
      return;
    end
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0; snap_irq = irq;
    n = 0;
    while (!rsp.b_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp.b_valid) begin n_tests++; n_fail++; $display("FAIL wr_bvalid_timeout addr=%h", a); end
    resp = rsp.b.resp;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [1:0] resp, output logic [31:0] d);
    int n = 0;
    req.ar.addr = a; req.ar_valid = 1'b1; req.r_ready = 1'b1;
    @(negedge clk);
    while (!rsp.ar_ready && n < 50) begin @(negedge clk); n++; end
    if (!rsp.ar_ready) begin
      n_tests++; n_fail++;
      $display("FAIL rd_accept_timeout addr=%h", a);
      req.ar_valid = 1'b0; req.r_ready = 1'b0; resp = 2'bxx; d = 'x;
      return;
    end
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    n = 0;
    while (!rsp.r_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp.r_valid) begin n_tests++; n_fail++; $display("FAIL rd_rvalid_timeout addr=%h", a); end
    resp = rsp.r.resp; d = rsp.r.data;
    @(posedge clk); #1;
    req.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] r; logic [31:0] d;
    req = '0; req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_tests++; if ({rsp.aw_ready, rsp.w_ready, rsp.ar_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_ready got=%b exp=000", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready}); end
    n_tests++; if ({rsp.b_valid, rsp.r_valid, rsp.b.resp, rsp.r.resp} !== 6'b0) begin n_fail++; $display("FAIL reset_valid_resp got=%b exp=0", {rsp.b_valid, rsp.r_valid, rsp.b.resp, rsp.r.resp}); end
    n_tests++; if (rsp.r.data !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rsp.r.data); end
    n_tests++; if ({irq, irq_edge} !== 8'h00) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", {irq, irq_edge}); end
    req = '0; rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      exp_resp_q.push_back(2'b00); exp_q.push_back(32'h1);
      axi_read(ra(c, 4), r, d);
      n_tests++; if ({r, d} !== {exp_resp_q.pop_front(), exp_q.pop_front()}) begin n_fail++; $display("FAIL reset_status ch=%0d got=%0d/%h exp=0/1", c, r, d); end
    end
    axi_read(ra(1, 8), r, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_thresh got=%h exp=0", d); end
  endtask

  task automatic test_fifo_order();
    logic [1:0] r; logic [31:0] d, e;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(32'hA5A5_0000 + 32'(i));
      axi_write(ra(2, 0), 32'hA5A5_0000 + 32'(i), r);
      n_tests++; if (r !== 2'b00) begin n_fail++; $display("FAIL fifo_push_resp i=%0d got=%0d exp=0", i, r); end
    end
    for (int i = 1; i <= 3; i++) begin
      axi_read(ra(2, 0), r, d);
      e = exp_q.pop_front();
      n_tests++; if ({r, d} !== {2'b00, e}) begin n_fail++; $display("FAIL fifo_pop i=%0d got=%0d/%h exp=0/%h", i, r, d, e); end
    end
    axi_read(ra(2, 4), r, d);
    n_tests++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL fifo_status got=%h exp=00000001", d); end
  endtask

  task automatic test_overflow();
    logic [1:0] r; logic [31:0] d; int e0;
    axi_write(ra(0, 8), 32'hFF, r);
    for (int i = 0; i < 8; i++) begin
      axi_write(ra(0, 0), 32'h100 + 32'(i), r);
      n_tests++; if (r !== 2'b00) begin n_fail++; $display("FAIL ovf_fill i=%0d got=%0d exp=0", i, r); end
    end
    axi_write(ra(0, 0), 32'hDEAD, r);
    n_tests++; if (r !== 2'b10) begin n_fail++; $display("FAIL ovf_resp got=%0d exp=2", r); end
    axi_read(ra(0, 4), r, d);
    n_tests++; if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL ovf_status got=%h exp=00000802", d); end
    axi_read(ra(0, 16), r, d);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL ovf_irqstat got=%h exp=2", d); end
    e0 = edge_cnt[0];
    axi_write(ra(0, 12), 32'h2, r);
    repeat (6) @(posedge clk); #1;
    n_tests++; if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL ovf_irq got=%b exp=1", irq[0]); end
    n_tests++; if (edge_cnt[0] - e0 !== 1) begin n_fail++; $display("FAIL ovf_edge_pulses got=%0d exp=1", edge_cnt[0] - e0); end
  endtask

  task automatic test_threshold();
    logic [1:0] r; logic [31:0] d;
    axi_write(ra(1, 8), 32'h1, r);
    axi_write(ra(1, 12), 32'h1, r);
    axi_write(ra(1, 0), 32'h11, r);
    axi_write(ra(1, 0), 32'h22, r);
    n_tests++; if (snap_irq[1] !== 1'b0) begin n_fail++; $display("FAIL thr_irq_early got=%b exp=0", snap_irq[1]); end
    n_tests++; if (irq[1] !== 1'b1) begin n_fail++; $display("FAIL thr_irq_2cyc got=%b exp=1", irq[1]); end
    axi_read(ra(1, 0), r, d);
    n_tests++; if (d !== 32'h11) begin n_fail++; $display("FAIL thr_pop got=%h exp=11", d); end
    axi_write(ra(1, 16), 32'h1, r);
    n_tests++; if (irq[1] !== 1'b0) begin n_fail++; $display("FAIL thr_clear got=%b exp=0", irq[1]); end
    axi_write(ra(1, 0), 32'h33, r);
    axi_write(ra(1, 16), 32'h1, r);
    axi_read(ra(1, 16), r, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL thr_set_wins got=%h exp=1", d); end
    n_tests++; if (irq[1] !== 1'b1) begin n_fail++; $display("FAIL thr_irq_held got=%b exp=1", irq[1]); end
  endtask

  task automatic test_underflow_range();
    logic [1:0] r; logic [31:0] d;
    axi_read(ra(3, 0), r, d);
    n_tests++; if ({r, d} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL udf_resp got=%0d/%h exp=2/0", r, d); end
    axi_read(ra(3, 16), r, d);
    n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL udf_irqstat got=%h exp=4", d); end
    axi_write(BASE + 32'h100, 32'h1, r);
    n_tests++; if (r !== 2'b10) begin n_fail++; $display("FAIL oor_write got=%0d exp=2", r); end
    axi_read(BASE + 32'h100, r, d);
    n_tests++; if ({r, d} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL oor_read got=%0d/%h exp=2/0", r, d); end
    axi_write(ra(3, 4), 32'h0, r);
    n_tests++; if (r !== 2'b10) begin n_fail++; $display("FAIL ro_write got=%0d exp=2", r); end
    axi_read(ra(0, 4), r, d);
    n_tests++; if (d !== 32'h0000_0802) begin n_fail++; $display("FAIL oor_no_effect got=%h exp=00000802", d); end
  endtask

  task automatic test_flush_wrap();
    logic [1:0] r; logic [31:0] d, e;
    for (int i = 0; i < 5; i++) axi_write(ra(2, 0), 32'hF0 + 32'(i), r);
    axi_write(ra(2, 20), 32'h1, r);
    n_tests++; if (r !== 2'b00) begin n_fail++; $display("FAIL flush_resp got=%0d exp=0", r); end
    axi_read(ra(2, 4), r, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL flush_status got=%h exp=1", d); end
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int i = 0; i < 6; i++) begin
        e = $urandom;
        exp_q.push_back(e);
        axi_write(ra(2, 0), e, r);
      end
      for (int i = 0; i < 6; i++) begin
        axi_read(ra(2, 0), r, d);
        e = exp_q.pop_front();
        n_tests++; if ({r, d} !== {2'b00, e}) begin n_fail++; $display("FAIL wrap_pop rnd=%0d i=%0d got=%0d/%h exp=0/%h", rnd, i, r, d, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int got = 0; int cycles = 0; logic g, e;
    rst_n = 1'b0; req = '0;
    @(posedge clk); #1; rst_n = 1'b1;
    exp_gnt_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    req.aw.addr = ra(0, 8); req.w.data = 32'h0; req.w.strb = 4'hF; req.ar.addr = ra(0, 4);
    req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1; req.b_ready = 1'b1; req.r_ready = 1'b1;
    while (got < 4 && cycles < 40) begin
      @(negedge clk); cycles++;
      if (rsp.aw_ready || rsp.ar_ready) begin
        g = rsp.ar_ready;
        e = exp_gnt_q.pop_front();
        n_tests++; if ({rsp.aw_ready, rsp.ar_ready} !== {~e, e}) begin n_fail++; $display("FAIL arb_grant n=%0d got_aw_ar=%b exp_read=%b", got, {rsp.aw_ready, g}, e); end
        got++;
      end
    end
    n_tests++; if (got !== 4) begin n_fail++; $display("FAIL arb_grant_count got=%0d exp=4", got); end
    req = '0;
    @(posedge clk); #1;
    req.aw.addr = ra(1, 4); req.w.data = 32'h0; req.w.strb = 4'hF;
    req.aw_valid = 1'b1; req.w_valid = 1'b1;
    @(negedge clk);
    n_tests++; if (rsp.aw_ready !== 1'b1) begin n_fail++; $display("FAIL bhold_accept got=%b exp=1", rsp.aw_ready); end
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar.addr = ra(1, 4); req.ar_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++; if ({rsp.b_valid, rsp.b.resp, rsp.aw_ready, rsp.ar_ready} !== 5'b11000) begin n_fail++; $display("FAIL bhold_stable i=%0d got=%b exp=11000", i, {rsp.b_valid, rsp.b.resp, rsp.aw_ready, rsp.ar_ready}); end
    end
    @(posedge clk); #1;
    req.ar_valid = 1'b0; req.b_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    n_tests++; if (rsp.b_valid !== 1'b0) begin n_fail++; $display("FAIL bhold_release got=%b exp=0", rsp.b_valid); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    req = '0; req.ar.addr = ra(0, 4); req.ar_valid = 1'b1;
    @(negedge clk);
    while (!rsp.ar_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    n_tests++; if (rsp.r_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_rvalid_pre got=%b exp=1", rsp.r_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({rsp.r_valid, rsp.r.data} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL rstmid_rvalid got=%b/%h exp=0/0", rsp.r_valid, rsp.r.data); end
    @(posedge clk); #1; rst_n = 1'b1; req.r_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (rsp.r_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_discard got=%b exp=0", rsp.r_valid); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_overflow();
    test_threshold();
    test_underflow_range();
    test_flush_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_mbox_array.md
# axi_lite_mbox_array

Parametrised AXI4-Lite mailbox array: one AXI4-Lite slave port serving `NumChannels` independent word FIFOs, each with a threshold interrupt, error flags and flush. It sits behind the 32-bit AXI4-Lite config crossbar and generalises the fixed two-channel host/cluster mailbox. Channel count, depth, base address and per-channel level or edge interrupt outputs are all configurable.

## Interface
- `NumChannels`, 4: number of mailbox channels, 1..16.
- `FifoDepth`, 8: words per channel FIFO; power of two, 2..256.
- `AxiAddrWidth`, 32: AXI4-Lite address width.
- `AxiDataWidth`, 32: AXI4-Lite data width; fixed at 32.
- `BaseAddr`, 32'h1040_2000: base of the register window; channel stride 0x40.
- `req_lite_t` / `resp_lite_t`, `ariane_axi_soc` lite types: AXI4-Lite request and response structs.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `slv_req_i`  in  req_lite_t  AXI4-Lite request.
- `slv_resp_o`  out  resp_lite_t  AXI4-Lite response.
- `irq_o`  out  NumChannels  per-channel level interrupt, registered.
- `irq_edge_o`  out  NumChannels  one-cycle pulse on each rising edge of `irq_o[c]`.

## Operation
- Address decode: `c = (addr - BaseAddr) >> 6`, offset `= addr[5:0]`. Any address outside `[BaseAddr, BaseAddr + 0x40*NumChannels)` returns SLVERR (2'b10) and has no side effect. Unmapped offsets and writes to RO registers also return SLVERR.
- Per-channel registers:
  - 0x00 DATA: write pushes `wdata` (`wstrb` ignored); read pops the head word.
  - 0x04 STATUS, RO: bit0 empty, bit1 full, bits[16:8] count.
  - 0x08 THRESH, RW, 8 bits: threshold.
  - 0x0C IRQ_EN, RW, bits[2:0]: per-flag enable.
  - 0x10 IRQ_STAT, W1C: bit0 threshold, bit1 overflow, bit2 underflow.
  - 0x14 CTRL, WO: bit0 flush, self-clearing.
- RW registers honour `wstrb` byte lanes.
- Write DATA when full: SLVERR, no push, IRQ_STAT.bit1 set.
- Read DATA when empty: SLVERR, `rdata = 0`, IRQ_STAT.bit2 set.
- Threshold flag: IRQ_STAT.bit0 is set every cycle in which `count > THRESH`. When a set and a W1C clear land in the same cycle, the set wins.
- `irq_o[c]` <= `|(IRQ_STAT[c] & IRQ_EN[c])`.
- `irq_edge_o[c] = irq_o[c] & ~irq_q[c]`.
- Flush: count, read pointer and write pointer go to 0. IRQ_STAT is not cleared.
- Count width `$clog2(FifoDepth+1)`. Pointers wrap modulo FifoDepth.
- Bus FSM states:
  - IDLE → WRESP when AW and W are both valid and the write is granted.
  - IDLE → RRESP when AR is valid and the read is granted.
  - WRESP → IDLE on `bready`.
  - RRESP → IDLE on `rready`.
- Arbitration: when AW+W and AR are both valid in IDLE, grant the type opposite to the last granted type; after reset the first contested grant goes to the read.
- AW alone (without W), or W alone, is not accepted; it waits.

## Timing
- Reset values:
  - all `*_ready` = 0; `bvalid` = `rvalid` = 0.
  - `bresp` = `rresp` = OKAY; `rdata` = 0.
  - all FIFOs empty; THRESH = IRQ_EN = IRQ_STAT = 0.
  - `irq_o` = `irq_edge_o` = 0; FSM in IDLE.
- Ready signals: `aw_ready` = `w_ready` = 1 only in IDLE, in the same cycle as the granted AW&W. `ar_ready` likewise for a granted AR.
- Side effects (push, pop, register update, flush) commit on the accept edge.
- `bvalid` or `rvalid` rises in the cycle after accept and is held with stable payload until the handshake.
- Minimum transaction spacing: 2 cycles (accept, response). The next accept can coincide with nothing; the FSM returns to IDLE first.
- STATUS reads reflect state before the accept edge.
- The threshold flag uses post-commit count. `irq_o` follows one cycle after IRQ_STAT changes, so push-to-irq is 2 cycles after accept.
- Reset asserted mid-transaction drops valid/ready immediately and discards the pending response.

## Test plan
- Push 0xA5A5_0001..0xA5A5_0003 to ch2, then pop 3 times → data returned in order, all OKAY; STATUS = 0x0000_0001 (empty, count 0).
- Fill ch0 with FifoDepth=8 words, then write a 9th word → SLVERR; STATUS count 8, full bit set; IRQ_STAT = 0x2; with IRQ_EN=0x2, `irq_o[0]` rises and `irq_edge_o[0]` pulses exactly once.
- Set THRESH=1 and IRQ_EN=1 on ch1; push 2 words → `irq_o[1]` high 2 cycles after the second accept. Pop one word, then write IRQ_STAT=1 → `irq_o[1]` falls. Write IRQ_STAT=1 while count is still 2 → the flag stays set.
- Pop from empty ch3 → SLVERR, `rdata` 0, IRQ_STAT bit2 set. Access `BaseAddr + 0x100` with NumChannels=4 → SLVERR, no state change.
- Assert AW+W and AR simultaneously, repeated 4 times → grants alternate R,W,R,W. Hold `bready` low 5 cycles → `bvalid` and `bresp` stay stable and no new accept occurs.
- Push 5 words, write CTRL=1 → STATUS count 0 and empty. Next push/pop round-trips correctly across pointer wrap. Assert reset mid-RRESP → `rvalid` 0 immediately.
